// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle controller: opcode constants, the
// controller state enumeration, accumulator-select codes, flag bit indices
// and the packed bundle of control outputs driven by the FSM.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    // Opcode classes. ALU ops are identified by ir[7:6]; everything else by ir[7:5].
    localparam logic [1:0] OP_CLASS_ALU = 2'b11;
    localparam logic [2:0] OP_LDM       = 3'b000;
    localparam logic [2:0] OP_STM       = 3'b001;
    localparam logic [2:0] OP_JMP       = 3'b010;
    localparam logic [2:0] OP_BRZ       = 3'b011;
    localparam logic [2:0] OP_BRC       = 3'b100;
    localparam logic [2:0] OP_HLT       = 3'b101;

    // Accumulator register-file index selects.
    localparam logic [1:0] ACC_SEL_DI = 2'b00;  // di[4:3], register of a two-byte op
    localparam logic [1:0] ACC_SEL_RS = 2'b01;  // ir[1:0], ALU source
    localparam logic [1:0] ACC_SEL_RD = 2'b10;  // ir[3:2], ALU destination

    // Bit positions inside the czn flag vector.
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, ADDR,
        M1, M2, M3,
        S1, S2, S3,
        J1,
        R1, R2, R3, R4,
        HALT
    } ctrlState_t;

    // All controller outputs in one bundle so a state can clear them with one assignment.
    typedef struct packed {
        logic       pcInc;
        logic       pcLd;
        logic       diLd;
        logic       irWe;
        logic       trWe;
        logic       memRe;
        logic       memWe;
        logic       bWe;
        logic       aWe;
        logic       accWe;
        logic       aluResWe;
        logic       ldCzn;
        logic       halted;
        logic       pcOrTr;
        logic       regOrMem;
        logic       bZero;
        logic       aZero;
        logic [1:0] accSel;
        logic [1:0] aluOp;
    } ctrlBus_t;

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Combinational opcode classifier. Exactly one class output is high for any
// defined opcode; 11x patterns fall into the ALU class.
//
// Ports:
//   ir     in  [7:0]  instruction register
//   isAlu  out        ALU op (ir[7:6] = 11)
//   isLdm  out        load from memory
//   isStm  out        store to memory
//   isJmp  out        unconditional jump
//   isBrz  out        branch if Z
//   isBrc  out        branch if C
//   isHlt  out        halt
// ---------------------------------------------------------------------------
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [7:0] ir,
    output logic       isAlu,
    output logic       isLdm,
    output logic       isStm,
    output logic       isJmp,
    output logic       isBrz,
    output logic       isBrc,
    output logic       isHlt
);

    logic [2:0] opcode;
    logic       unusedOperand;

    assign opcode = ir[7:5];

    assign isAlu = (ir[7:6] == OP_CLASS_ALU);
    assign isLdm = (opcode == OP_LDM);
    assign isStm = (opcode == OP_STM);
    assign isJmp = (opcode == OP_JMP);
    assign isBrz = (opcode == OP_BRZ);
    assign isBrc = (opcode == OP_BRC);
    assign isHlt = (opcode == OP_HLT);

    // Operand bits carry register/address fields that play no part in classification.
    assign unusedOperand = ^ir[4:0];

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Moore FSM sequencing a small multicycle accumulator CPU datapath:
// FETCH -> DECODE -> {ALU R1-R4 | ADDR -> LDM M1-M3 / STM S1-S3 / J1 | HALT}.
//
// Configuration:
//   CTRL_BRANCH_EN  defined   : BRZ/BRC load the PC when Z/C is set in J1.
//                   undefined : BRZ/BRC still walk ADDR and J1 but never load the PC.
//
// Parameters:
//   ALU_PASS    ALU op code that yields B+0 (used for memory transfers)
//
// Ports:
//   clk, rst    clock; asynchronous active-high reset (forces IDLE, all outputs 0)
//   ir [7:0]    instruction register
//   di [4:0]    latched IR[4:0] (consumed by the datapath, not by the FSM)
//   czn [2:0]   flags C=[0], Z=[1], N=[2]; only looked at in J1
//   pc_inc, pc_ld, di_ld, ir_we, tr_we, mem_re, mem_we, b_we, a_we, acc_we,
//   alu_res_we, ld_czn, halted        1-bit strobes / status
//   pc_or_tr    address mux, 1 = PC, 0 = TR
//   reg_or_mem  B source, 1 = accumulator, 0 = memory
//   b_zero, a_zero  force ALU input to 0
//   acc_sel [1:0]   00 = di[4:3], 01 = ir[1:0], 10 = ir[3:2]
//   alu_op  [1:0]   ALU operation
// ---------------------------------------------------------------------------
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter logic [1:0] ALU_PASS = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic [4:0] di,
    input  logic [2:0] czn,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       di_ld,
    output logic       ir_we,
    output logic       tr_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       b_we,
    output logic       a_we,
    output logic       acc_we,
    output logic       alu_res_we,
    output logic       ld_czn,
    output logic       halted,
    output logic       pc_or_tr,
    output logic       reg_or_mem,
    output logic       b_zero,
    output logic       a_zero,
    output logic [1:0] acc_sel,
    output logic [1:0] alu_op
);

    ctrlState_t currState;
    ctrlState_t nextState;
    ctrlBus_t   ctrl;

    logic isAlu, isLdm, isStm, isJmp, isBrz, isBrc, isHlt;
    logic branchTaken;
    logic unusedFlags;
    logic unusedDi;

    ctrl_decode uDecode (
        .ir    (ir),
        .isAlu (isAlu),
        .isLdm (isLdm),
        .isStm (isStm),
        .isJmp (isJmp),
        .isBrz (isBrz),
        .isBrc (isBrc),
        .isHlt (isHlt)
    );

`ifdef CTRL_BRANCH_EN
    assign branchTaken = isJmp | (isBrz & czn[FLAG_Z]) | (isBrc & czn[FLAG_C]);
    assign unusedFlags = czn[FLAG_N];
`else
    assign branchTaken = isJmp;
    assign unusedFlags = ^{czn[FLAG_N], czn[FLAG_Z], czn[FLAG_C], isBrz, isBrc};
`endif

    // di only feeds the datapath register-file mux; the FSM never inspects it.
    assign unusedDi = ^di;

    // NOTE: async reset lives in the sensitivity list; state updates use <= so
    // every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            currState <= IDLE;
        end else begin
            currState <= nextState;
        end
    end

    // NOTE: every output and the next state get a default before the case, so
    // no path through this block can leave a signal unassigned (no latches).
    always_comb begin
        nextState = IDLE;
        ctrl      = '0;

        unique case (currState)
            IDLE: begin
                nextState = FETCH;
            end

            FETCH: begin
                ctrl.pcOrTr = 1'b1;
                ctrl.memRe  = 1'b1;
                ctrl.irWe   = 1'b1;
                ctrl.pcInc  = 1'b1;
                nextState   = DECODE;
            end

            DECODE: begin
                if (isAlu) begin
                    nextState = R1;
                end else if (isHlt) begin
                    nextState = HALT;
                end else if (isLdm || isStm || isJmp || isBrz || isBrc) begin
                    nextState = ADDR;
                end else begin
                    nextState = FETCH;  // undefined opcode executes as NOP
                end
            end

            // Second byte goes to TR; di captures the first byte's address bits.
            ADDR: begin
                ctrl.pcOrTr = 1'b1;
                ctrl.memRe  = 1'b1;
                ctrl.trWe   = 1'b1;
                ctrl.diLd   = 1'b1;
                ctrl.pcInc  = 1'b1;
                if (isLdm) begin
                    nextState = M1;
                end else if (isStm) begin
                    nextState = S1;
                end else begin
                    nextState = J1;
                end
            end

            M1: begin
                ctrl.memRe = 1'b1;
                ctrl.bWe   = 1'b1;
                nextState  = M2;
            end
            M2: begin
                ctrl.aZero    = 1'b1;
                ctrl.aluOp    = ALU_PASS;
                ctrl.aluResWe = 1'b1;
                nextState     = M3;
            end
            M3: begin
                ctrl.accSel = ACC_SEL_DI;
                ctrl.accWe  = 1'b1;
                nextState   = FETCH;
            end

            S1: begin
                ctrl.accSel   = ACC_SEL_DI;
                ctrl.regOrMem = 1'b1;
                ctrl.bWe      = 1'b1;
                nextState     = S2;
            end
            S2: begin
                ctrl.aZero    = 1'b1;
                ctrl.aluOp    = ALU_PASS;
                ctrl.aluResWe = 1'b1;
                nextState     = S3;
            end
            S3: begin
                ctrl.memWe = 1'b1;
                nextState  = FETCH;
            end

            // Flags are consulted here and nowhere else.
            J1: begin
                ctrl.pcLd = branchTaken;
                nextState = FETCH;
            end

            R1: begin
                ctrl.accSel = ACC_SEL_RS;
                ctrl.aWe    = 1'b1;
                nextState   = R2;
            end
            R2: begin
                ctrl.accSel   = ACC_SEL_RD;
                ctrl.regOrMem = 1'b1;
                ctrl.bWe      = 1'b1;
                nextState     = R3;
            end
            R3: begin
                ctrl.aluOp    = ir[5:4];
                ctrl.aluResWe = 1'b1;
                ctrl.ldCzn    = 1'b1;
                nextState     = R4;
            end
            R4: begin
                ctrl.accSel = ACC_SEL_RD;
                ctrl.accWe  = 1'b1;
                nextState   = FETCH;
            end

            HALT: begin
                ctrl.halted = 1'b1;
                nextState   = HALT;
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign pc_inc     = ctrl.pcInc;
    assign pc_ld      = ctrl.pcLd;
    assign di_ld      = ctrl.diLd;
    assign ir_we      = ctrl.irWe;
    assign tr_we      = ctrl.trWe;
    assign mem_re     = ctrl.memRe;
    assign mem_we     = ctrl.memWe;
    assign b_we       = ctrl.bWe;
    assign a_we       = ctrl.aWe;
    assign acc_we     = ctrl.accWe;
    assign alu_res_we = ctrl.aluResWe;
    assign ld_czn     = ctrl.ldCzn;
    assign halted     = ctrl.halted;
    assign pc_or_tr   = ctrl.pcOrTr;
    assign reg_or_mem = ctrl.regOrMem;
    assign b_zero     = ctrl.bZero;
    assign a_zero     = ctrl.aZero;
    assign acc_sel    = ctrl.accSel;
    assign alu_op     = ctrl.aluOp;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Scoreboarded bench: each instruction pushes its expected per-cycle control
// vectors (plus the ir/di/czn to drive in that cycle) onto a queue; the test
// tasks pop one entry per cycle and compare on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    // A non-zero pass code makes the M2/S2 alu_op field observable.
    localparam logic [1:0] ALU_PASS = 2'b10;

`ifdef CTRL_BRANCH_EN
    localparam logic BRANCH_EN = 1'b1;
`else
    localparam logic BRANCH_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ir;
    logic [4:0] di;
    logic [2:0] czn;
    logic pc_inc, pc_ld, di_ld, ir_we, tr_we, mem_re, mem_we, b_we, a_we;
    logic acc_we, alu_res_we, ld_czn, halted, pc_or_tr, reg_or_mem, b_zero, a_zero;
    logic [1:0] acc_sel, alu_op;

    multicycle_controller #(.ALU_PASS(ALU_PASS)) dut (
        .clk(clk), .rst(rst), .ir(ir), .di(di), .czn(czn),
        .pc_inc(pc_inc), .pc_ld(pc_ld), .di_ld(di_ld), .ir_we(ir_we), .tr_we(tr_we),
        .mem_re(mem_re), .mem_we(mem_we), .b_we(b_we), .a_we(a_we), .acc_we(acc_we),
        .alu_res_we(alu_res_we), .ld_czn(ld_czn), .halted(halted), .pc_or_tr(pc_or_tr),
        .reg_or_mem(reg_or_mem), .b_zero(b_zero), .a_zero(a_zero),
        .acc_sel(acc_sel), .alu_op(alu_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcInc, pcLd, diLd, irWe, trWe, memRe, memWe, bWe, aWe, accWe;
        logic aluResWe, ldCzn, halted, pcOrTr, regOrMem, bZero, aZero;
        logic [1:0] accSel;
        logic [1:0] aluOp;
    } outVec_t;

    typedef struct {
        string      name;
        logic [7:0] ir;
        logic [2:0] czn;
        outVec_t    exp;
    } sbEntry_t;

    sbEntry_t sbQueue[$];
    int       checks = 0;
    int       errors = 0;
    int       exclViolations = 0;
    logic     memWeSeen = 1'b0;
    outVec_t  observed;

    assign observed = {pc_inc, pc_ld, di_ld, ir_we, tr_we, mem_re, mem_we, b_we, a_we,
                       acc_we, alu_res_we, ld_czn, halted, pc_or_tr, reg_or_mem,
                       b_zero, a_zero, acc_sel, alu_op};

    // Mutual-exclusion monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if ((mem_re === 1'b1 && mem_we === 1'b1) || (pc_inc === 1'b1 && pc_ld === 1'b1))
            exclViolations++;
    end

    always @(posedge mem_we) memWeSeen = 1'b1;

    // ---------------- expected control vectors, one per state ----------------
    function automatic outVec_t vFetch();
        outVec_t v = '0;
        v.pcOrTr = 1'b1; v.memRe = 1'b1; v.irWe = 1'b1; v.pcInc = 1'b1;
        return v;
    endfunction
    function automatic outVec_t vAddr();
        outVec_t v = '0;
        v.pcOrTr = 1'b1; v.memRe = 1'b1; v.trWe = 1'b1; v.diLd = 1'b1; v.pcInc = 1'b1;
        return v;
    endfunction
    function automatic outVec_t vPass();  // M2 and S2
        outVec_t v = '0;
        v.aZero = 1'b1; v.aluOp = ALU_PASS; v.aluResWe = 1'b1;
        return v;
    endfunction

    task automatic pushEntry(input string n, input logic [7:0] irv, input logic [2:0] c,
                             input outVec_t e);
        sbEntry_t s;
        s.name = n; s.ir = irv; s.czn = c; s.exp = e;
        sbQueue.push_back(s);
    endtask

    // Advance to the next falling edge, drive that cycle's inputs, let outputs settle.
    task automatic nextEntry(output sbEntry_t e);
        @(negedge clk);
        e   = sbQueue.pop_front();
        ir  = e.ir;
        di  = e.ir[4:0];
        czn = e.czn;
        #1;
    endtask

    // ---------------- per-instruction expected sequences ----------------
    task automatic pushAlu(input logic [7:0] irv);
        outVec_t v;
        pushEntry($sformatf("alu %h DECODE", irv), irv, 3'b000, '0);
        v = '0; v.accSel = 2'b01; v.aWe = 1'b1;
        pushEntry($sformatf("alu %h R1", irv), irv, 3'b000, v);
        v = '0; v.accSel = 2'b10; v.regOrMem = 1'b1; v.bWe = 1'b1;
        pushEntry($sformatf("alu %h R2", irv), irv, 3'b000, v);
        v = '0; v.aluOp = irv[5:4]; v.aluResWe = 1'b1; v.ldCzn = 1'b1;
        pushEntry($sformatf("alu %h R3", irv), irv, 3'b000, v);
        v = '0; v.accSel = 2'b10; v.accWe = 1'b1;
        pushEntry($sformatf("alu %h R4", irv), irv, 3'b000, v);
        pushEntry($sformatf("alu %h next FETCH", irv), irv, 3'b000, vFetch());
    endtask

    task automatic pushLdm(input logic [7:0] irv);
        outVec_t v;
        pushEntry($sformatf("ldm %h DECODE", irv), irv, 3'b111, '0);
        pushEntry($sformatf("ldm %h ADDR", irv), irv, 3'b111, vAddr());
        v = '0; v.memRe = 1'b1; v.bWe = 1'b1;
        pushEntry($sformatf("ldm %h M1", irv), irv, 3'b111, v);
        pushEntry($sformatf("ldm %h M2", irv), irv, 3'b111, vPass());
        v = '0; v.accSel = 2'b00; v.accWe = 1'b1;
        pushEntry($sformatf("ldm %h M3", irv), irv, 3'b111, v);
        pushEntry($sformatf("ldm %h next FETCH", irv), irv, 3'b111, vFetch());
    endtask

    task automatic pushStmHead(input logic [7:0] irv);
        outVec_t v;
        pushEntry($sformatf("stm %h DECODE", irv), irv, 3'b000, '0);
        pushEntry($sformatf("stm %h ADDR", irv), irv, 3'b000, vAddr());
        v = '0; v.accSel = 2'b00; v.regOrMem = 1'b1; v.bWe = 1'b1;
        pushEntry($sformatf("stm %h S1", irv), irv, 3'b000, v);
        pushEntry($sformatf("stm %h S2", irv), irv, 3'b000, vPass());
    endtask

    task automatic pushStm(input logic [7:0] irv);
        outVec_t v;
        pushStmHead(irv);
        v = '0; v.memWe = 1'b1;
        pushEntry($sformatf("stm %h S3", irv), irv, 3'b000, v);
        pushEntry($sformatf("stm %h next FETCH", irv), irv, 3'b000, vFetch());
    endtask

    // cEarly drives DECODE/ADDR, cJ1 drives J1; taken is the expected pc_ld.
    task automatic pushBranch(input logic [7:0] irv, input logic [2:0] cEarly,
                              input logic [2:0] cJ1, input logic taken);
        outVec_t v;
        pushEntry($sformatf("br %h czn %b DECODE", irv, cJ1), irv, cEarly, '0);
        pushEntry($sformatf("br %h czn %b ADDR", irv, cJ1), irv, cEarly, vAddr());
        v = '0; v.pcLd = taken;
        pushEntry($sformatf("br %h czn %b J1", irv, cJ1), irv, cJ1, v);
        pushEntry($sformatf("br %h czn %b next FETCH", irv, cJ1), irv, cJ1, vFetch());
    endtask

    // ---------------- test tasks ----------------
    task automatic test_reset();
        sbEntry_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (observed !== outVec_t'('0)) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, observed, outVec_t'('0));
            end
        end
        rst = 1'b0;
        pushEntry("reset first FETCH", 8'h00, 3'b000, vFetch());
        nextEntry(e);
        checks++;
        if (observed !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, observed, e.exp);
        end
    endtask

    task automatic test_alu();
        sbEntry_t e;
        pushAlu(8'hD6);
        pushAlu(8'hF3);
        pushAlu(8'hC0);
        while (sbQueue.size() > 0) begin
            nextEntry(e);
            checks++;
            if (observed !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observed, e.exp);
            end
        end
    endtask

    task automatic test_ldm();
        sbEntry_t e;
        pushLdm(8'h1A);
        while (sbQueue.size() > 0) begin
            nextEntry(e);
            checks++;
            if (observed !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observed, e.exp);
            end
        end
    endtask

    task automatic test_stm();
        sbEntry_t e;
        pushStm(8'h3F);
        while (sbQueue.size() > 0) begin
            nextEntry(e);
            checks++;
            if (observed !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observed, e.exp);
            end
        end
    endtask

    task automatic test_branch();
        sbEntry_t e;
        pushBranch(8'h40, 3'b000, 3'b000, 1'b1);        // JMP always loads
        pushBranch(8'h60, 3'b010, 3'b010, BRANCH_EN);   // BRZ, Z set
        pushBranch(8'h60, 3'b000, 3'b000, 1'b0);        // BRZ, Z clear
        pushBranch(8'h60, 3'b101, 3'b101, 1'b0);        // BRZ, C and N only
        pushBranch(8'h80, 3'b001, 3'b001, BRANCH_EN);   // BRC, C set
        pushBranch(8'h80, 3'b110, 3'b110, 1'b0);        // BRC, C clear
        pushBranch(8'h60, 3'b010, 3'b000, 1'b0);        // Z only before J1
        pushBranch(8'h7F, 3'b000, 3'b010, BRANCH_EN);   // Z appears in J1
        pushBranch(8'h8C, 3'b111, 3'b110, 1'b0);        // C drops in J1
        while (sbQueue.size() > 0) begin
            nextEntry(e);
            checks++;
            if (observed !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observed, e.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        sbEntry_t e;
        pushAlu(8'hE5);
        pushLdm(8'h05);
        pushBranch(8'h9F, 3'b001, 3'b001, BRANCH_EN);
        pushStm(8'h22);
        pushBranch(8'h5F, 3'b000, 3'b000, 1'b1);
        pushAlu(8'hDB);
        while (sbQueue.size() > 0) begin
            nextEntry(e);
            checks++;
            if (observed !== e.exp) begin
                errors++;
                $display("FAIL b2b %s: got %h expected %h", e.name, observed, e.exp);
            end
        end
    endtask

    task automatic test_halt();
        sbEntry_t e;
        outVec_t  v;
        pushEntry("hlt DECODE", 8'hA0, 3'b000, '0);
        v = '0; v.halted = 1'b1;
        for (int i = 0; i < 10; i++)
            pushEntry($sformatf("hlt HALT cycle %0d", i), 8'hA0, 3'b011, v);
        while (sbQueue.size() > 0) begin
            nextEntry(e);
            checks++;
            if (observed !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observed, e.exp);
            end
        end
        // Reset between clock edges must clear HALT immediately.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (observed !== outVec_t'('0)) begin
            errors++;
            $display("FAIL hlt async reset: got %h expected %h", observed, outVec_t'('0));
        end
        @(negedge clk);
        rst = 1'b0;
        pushEntry("hlt after reset FETCH", 8'hA0, 3'b000, vFetch());
        nextEntry(e);
        checks++;
        if (observed !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, observed, e.exp);
        end
    endtask

    task automatic test_abort();
        sbEntry_t e;
        memWeSeen = 1'b0;
        pushStmHead(8'h2C);
        while (sbQueue.size() > 0) begin
            nextEntry(e);
            checks++;
            if (observed !== e.exp) begin
                errors++;
                $display("FAIL abort %s: got %h expected %h", e.name, observed, e.exp);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (observed !== outVec_t'('0)) begin
            errors++;
            $display("FAIL abort immediate IDLE: got %h expected %h", observed, outVec_t'('0));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (observed !== outVec_t'('0)) begin
                errors++;
                $display("FAIL abort held reset %0d: got %h expected %h", i, observed, outVec_t'('0));
            end
        end
        rst = 1'b0;
        pushEntry("abort restart FETCH", 8'h2C, 3'b000, vFetch());
        nextEntry(e);
        checks++;
        if (observed !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, observed, e.exp);
        end
        checks++;
        if (memWeSeen !== 1'b0) begin
            errors++;
            $display("FAIL abort mem_we seen: got %b expected %b", memWeSeen, 1'b0);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (exclViolations !== 0) begin
            errors++;
            $display("FAIL exclusive strobes: got %0d violations expected 0", exclViolations);
        end
    endtask

    initial begin
        rst = 1'b1;
        ir  = 8'h00;
        di  = 5'h00;
        czn = 3'b000;
        test_reset();
        test_alu();
        test_ldm();
        test_stm();
        test_branch();
        test_back_to_back();
        test_halt();
        test_abort();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
